// File: rtl/score_keeper.sv
`default_nettype none
// ============================================================================
// score_keeper : per-frame hit commit, BCD score, lives, wave progression.
// Optional macro WAVE_BONUS_EN adds BONUS_POINTS on wave clear.   Rev 1.0
// ============================================================================
module score_keeper #(
  parameter int NUM_ALIENS   = 15,
  parameter int HIT_POINTS   = 10,
  parameter int START_LIVES  = 3,
  parameter int CLEAR_FRAMES = 120,
  parameter int BONUS_POINTS = 100
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  frame_vs,
  input  logic                  Alien_hit,
  input  logic [3:0]            Hit_idx,
  input  logic                  Ship_hit,
  input  logic                  Start,
  output logic [NUM_ALIENS-1:0] Alive,
  output logic                  Missile_clr,
  output logic [15:0]           Score_bcd,
  output logic [3:0]            Lives,
  output logic [3:0]            Wave,
  output logic [1:0]            State
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_PLAY  = 2'b01,
    S_CLEAR = 2'b10,
    S_OVER  = 2'b11
  } state_t;

  function automatic logic [15:0] to_bcd(input int v);
    to_bcd = {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Digit-serial BCD add; a carry out of the thousands digit pins the score at 9999.
  function automatic logic [15:0] bcd_add_sat(input logic [15:0] a, input logic [15:0] b);
    logic [4:0]  s;
    logic        c;
    logic [15:0] r;
    c = 1'b0;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      s = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'd0, c};
      if (s > 5'd9) begin
        s = s - 5'd10;
        c = 1'b1;
      end else begin
        c = 1'b0;
      end
      r[4*i +: 4] = s[3:0];
    end
    bcd_add_sat = c ? 16'h9999 : r;
  endfunction

  localparam int                  CW          = (CLEAR_FRAMES > 1) ? $clog2(CLEAR_FRAMES) : 1;
  localparam logic [15:0]         c_hit_bcd   = to_bcd(HIT_POINTS);
  localparam logic [15:0]         c_bonus_bcd = to_bcd(BONUS_POINTS);
  localparam logic [3:0]          c_lives     = 4'(START_LIVES);
  localparam logic [CW-1:0]       c_last_cnt  = CW'(CLEAR_FRAMES - 1);
  localparam logic [NUM_ALIENS-1:0] c_one     = NUM_ALIENS'(1);
`ifdef WAVE_BONUS_EN
  localparam bit                  c_bonus_en  = 1'b1;
`else
  localparam bit                  c_bonus_en  = 1'b0;
`endif

  state_t                  state_q, state_d;
  logic [NUM_ALIENS-1:0]   alive_q, alive_d, sel_d;
  logic [15:0]             score_q, score_d;
  logic [3:0]              lives_q, lives_d, wave_q, wave_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    mclr_q, mclr_d;
  logic                    alat_q, alat_d, slat_q, slat_d;
  logic [3:0]              aidx_q, aidx_d;
  logic                    vs_q, vs_old_q;
  logic                    tick_d, kill_d;

  assign tick_d = vs_old_q & ~vs_q;

  always_comb begin
    state_d = state_q;
    alive_d = alive_q;
    score_d = score_q;
    lives_d = lives_q;
    wave_d  = wave_q;
    cnt_d   = cnt_q;
    mclr_d  = 1'b0;
    alat_d  = alat_q;
    aidx_d  = aidx_q;
    slat_d  = slat_q;
    kill_d  = 1'b0;
    sel_d   = alive_q >> aidx_q;

    if (state_q == S_PLAY) begin
      if (Alien_hit && !alat_q) begin
        alat_d = 1'b1;
        aidx_d = Hit_idx;
      end
      if (Ship_hit) slat_d = 1'b1;
    end

    if (tick_d) begin
      alat_d = 1'b0;
      slat_d = 1'b0;
      unique case (state_q)
        S_PLAY: begin
          kill_d = alat_q && ({28'd0, aidx_q} < 32'(NUM_ALIENS)) && sel_d[0];
          if (kill_d) begin
            alive_d = alive_q & ~(c_one << aidx_q);
            score_d = bcd_add_sat(score_q, c_hit_bcd);
            mclr_d  = 1'b1;
          end
          if (slat_q) begin
            if (lives_q <= 4'd1) begin
              lives_d = 4'd0;
              state_d = S_OVER;
            end else begin
              lives_d = lives_q - 4'd1;
            end
          end
          // A simultaneous last-life loss keeps GAME_OVER ahead of the wave clear.
          if (state_d == S_PLAY && alive_d == '0) begin
            state_d = S_CLEAR;
            cnt_d   = '0;
            if (c_bonus_en) score_d = bcd_add_sat(score_d, c_bonus_bcd);
          end
        end
        S_CLEAR: begin
          if (cnt_q == c_last_cnt) begin
            state_d = S_PLAY;
            alive_d = '1;
            wave_d  = wave_q + 4'd1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: ;
      endcase
    end

    if (state_q == S_IDLE && Start) state_d = S_PLAY;
    if (state_q == S_OVER && Start) begin
      state_d = S_IDLE;
      score_d = '0;
      lives_d = c_lives;
      wave_d  = 4'd0;
      alive_d = '1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= S_IDLE;
      alive_q  <= '1;
      score_q  <= '0;
      lives_q  <= c_lives;
      wave_q   <= 4'd0;
      cnt_q    <= '0;
      mclr_q   <= 1'b0;
      alat_q   <= 1'b0;
      aidx_q   <= 4'd0;
      slat_q   <= 1'b0;
      vs_q     <= 1'b1;
      vs_old_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      alive_q  <= alive_d;
      score_q  <= score_d;
      lives_q  <= lives_d;
      wave_q   <= wave_d;
      cnt_q    <= cnt_d;
      mclr_q   <= mclr_d;
      alat_q   <= alat_d;
      aidx_q   <= aidx_d;
      slat_q   <= slat_d;
      vs_q     <= frame_vs;
      vs_old_q <= vs_q;
    end
  end

  assign Alive       = alive_q;
  assign Missile_clr = mclr_q;
  assign Score_bcd   = score_q;
  assign Lives       = lives_q;
  assign Wave        = wave_q;
  assign State       = state_q;

endmodule
`default_nettype wire

// File: tb/tb_score_keeper.sv
`default_nettype none
// tb_score_keeper : randomized frames against a frame-level game model.
module tb_score_keeper;

  localparam int N_AL   = 15;
  localparam int PTS    = 10;
  localparam int LIVES0 = 3;
  localparam int CLRF   = 120;
`ifdef WAVE_BONUS_EN
  localparam int BONUS  = 100;
`else
  localparam int BONUS  = 0;
`endif

  logic            Clk = 1'b0;
  logic            Reset_n = 1'b1;
  logic            frame_vs = 1'b1;
  logic            Alien_hit = 1'b0;
  logic [3:0]      Hit_idx = 4'd0;
  logic            Ship_hit = 1'b0;
  logic            Start = 1'b0;
  logic [N_AL-1:0] Alive;
  logic            Missile_clr;
  logic [15:0]     Score_bcd;
  logic [3:0]      Lives;
  logic [3:0]      Wave;
  logic [1:0]      State;

  score_keeper dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_vs(frame_vs), .Alien_hit(Alien_hit),
    .Hit_idx(Hit_idx), .Ship_hit(Ship_hit), .Start(Start), .Alive(Alive),
    .Missile_clr(Missile_clr), .Score_bcd(Score_bcd), .Lives(Lives), .Wave(Wave),
    .State(State)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  // Game model: 0 IDLE, 1 PLAY, 2 WAVE_CLEAR, 3 GAME_OVER
  bit [N_AL-1:0] m_alive;
  int m_score, m_lives, m_wave, m_state, m_cnt, m_pulses;

  always @(negedge Clk) if (Missile_clr === 1'b1) pulses++;

  initial begin
    #900000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] bcd(input int v);
    bcd = {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic int sat(input int v);
    sat = (v > 9999) ? 9999 : v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".state"}, 32'(State), 32'(m_state));
    chk({tag, ".alive"}, 32'(Alive), 32'(m_alive));
    chk({tag, ".score"}, 32'(Score_bcd), 32'(bcd(m_score)));
    chk({tag, ".lives"}, 32'(Lives), 32'(m_lives));
    chk({tag, ".wave"}, 32'(Wave), 32'(m_wave));
    chk({tag, ".mclr_cycles"}, 32'(pulses), 32'(m_pulses));
  endtask

  task automatic model_reset();
    m_alive = '1; m_score = 0; m_lives = LIVES0; m_wave = 0; m_state = 0; m_cnt = 0;
  endtask

  // Start held for ncyc cycles, one state step per cycle.
  task automatic start(input int ncyc, input string tag);
    pulses = 0; m_pulses = 0;
    for (int i = 0; i < ncyc; i++) begin
      Start = 1'b1;
      @(negedge Clk);
      if (m_state == 0) m_state = 1;
      else if (m_state == 3) begin
        model_reset();
      end
    end
    Start = 1'b0;
    @(negedge Clk);
    check_all(tag);
  endtask

  // One video frame: nhit cycles of idx1, optional idx2 hit, optional ship hit, then vsync.
  task automatic frame(input int nhit, input int idx1, input int idx2, input bit ship,
                       input string tag);
    bit alat, slat;
    int aidx;
    alat = (m_state == 1) && (nhit > 0 || idx2 >= 0);
    aidx = (nhit > 0) ? idx1 : idx2;
    slat = (m_state == 1) && ship;
    pulses = 0; m_pulses = 0;
    for (int i = 0; i < nhit; i++) begin
      Alien_hit = 1'b1; Hit_idx = 4'(idx1); @(negedge Clk);
    end
    if (idx2 >= 0) begin
      Alien_hit = 1'b1; Hit_idx = 4'(idx2); @(negedge Clk);
    end
    Alien_hit = 1'b0;
    if (ship) begin
      Ship_hit = 1'b1; @(negedge Clk);
    end
    Ship_hit = 1'b0;
    frame_vs = 1'b0; @(negedge Clk);
    frame_vs = 1'b1;
    repeat (3) @(negedge Clk);
    if (m_state == 1) begin
      if (alat && aidx < N_AL && m_alive[aidx]) begin
        m_alive[aidx] = 1'b0;
        m_score = sat(m_score + PTS);
        m_pulses = 1;
      end
      if (slat) begin
        if (m_lives == 1) begin m_lives = 0; m_state = 3; end
        else m_lives = m_lives - 1;
      end
      if (m_state == 1 && m_alive == 0) begin
        m_state = 2; m_cnt = 0; m_score = sat(m_score + BONUS);
      end
    end else if (m_state == 2) begin
      m_cnt++;
      if (m_cnt == CLRF) begin m_state = 1; m_alive = '1; m_wave = (m_wave + 1) % 16; end
    end
    check_all(tag);
  endtask

  function automatic int first_alive();
    first_alive = 0;
    for (int i = N_AL - 1; i >= 0; i--) if (m_alive[i]) first_alive = i;
  endfunction

  task automatic finish_wave(input string tag);
    for (int g = 0; g < 400 && m_state == 1; g++) frame(1, first_alive(), -1, 1'b0, tag);
    for (int g = 0; g < 400 && m_state == 2; g++)
      frame($urandom_range(0, 2), $urandom_range(0, 15), -1, $urandom_range(0, 1) == 1, tag);
  endtask

  initial begin
    int sat_kills;
    model_reset();
    #1 Reset_n = 1'b0;
    #1 pulses = 0; m_pulses = 0;
    check_all("reset");
    @(negedge Clk); Reset_n = 1'b1;
    @(negedge Clk);

    start(1, "start");
    frame(200, 3, -1, 1'b0, "kill3");
    frame(1, 5, 6, 1'b0, "first_of_two");
    frame(1, 5, -1, 1'b0, "dead_idx");
    frame(2, 15, -1, 1'b0, "idx_out_of_range");

    for (int f = 0; f < 30; f++)
      frame($urandom_range(0, 3), $urandom_range(0, 15),
            ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 15)) : -1, 1'b0, "rand");
    finish_wave("wave1");

    frame(1, first_alive(), -1, 1'b1, "kill_and_ship");
    frame(0, 0, -1, 1'b1, "ship2");
    frame(0, 0, -1, 1'b1, "ship3_over");
    frame(3, 0, -1, 1'b1, "hits_in_over");
    start(1, "over_to_idle");
    frame(2, 1, -1, 1'b0, "hits_in_idle");

    start(1, "restart");
    for (int f = 0; f < 3; f++) frame(0, 0, -1, 1'b1, "ship_loop");
    start(2, "hold_start");

    sat_kills = 0;
    for (int g = 0; g < 20000 && sat_kills < 3; g++) begin
      if (m_state == 2) frame(0, 0, -1, 1'b0, "sat_clear");
      else begin
        frame(1, first_alive(), -1, 1'b0, "sat_kill");
        if (m_score == 9999) sat_kills++;
      end
    end
    chk("saturated", 32'(Score_bcd), 32'h9999);

    if (m_state == 2) finish_wave("pre_reset");
    Alien_hit = 1'b1; Hit_idx = 4'(first_alive());
    repeat (2) @(negedge Clk);
    #2 Reset_n = 1'b0;
    #1 model_reset(); pulses = 0; m_pulses = 0;
    check_all("async_reset");
    Alien_hit = 1'b0;
    @(negedge Clk); Reset_n = 1'b1;
    @(negedge Clk);
    start(1, "post_reset_start");
    frame(0, 0, -1, 1'b0, "latch_discarded");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
